pipeline_controller: RTL and testbench

//  Central stall/flush/valid sequencer for the N-stage RISC-V core (stage 0=IF ... N-1=WB).

---
 rtl/common_pkg.sv | 17 +
 rtl/pipe_perf_cnt.sv | 31 +++
 rtl/pipeline_controller.sv | 141 ++++++++++++++
 tb/tb_pipeline_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared pipeline-control types: sequencer states and stage index names.
package common_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Cycle / retire / stall / flush performance counters, wrapping at 2^CNT_W.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             cycle_en,
  input  logic             instret_en,
  input  logic             stall_en,
  input  logic             flush_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (cycle_en)   cycle_cnt   <= cycle_cnt + 1'b1;
      if (instret_en) instret_cnt <= instret_cnt + 1'b1;
      if (stall_en)   stall_cnt   <= stall_cnt + 1'b1;
      if (flush_en)   flush_cnt   <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush/valid sequencer for the in-order core: per-register enable and
// bubble strobes, per-stage valid tracking, start-up gating and halt drain.
module pipeline_controller
  import common_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  output logic [NUM_STAGES-1:0] reg_en,
  output logic [NUM_STAGES-1:0] reg_bubble,
  output logic                  redirect,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  // Returns {found, index of highest set bit}.
  function automatic logic [IDX_W:0] top_bit(input logic [NUM_STAGES-1:0] v);
    logic [IDX_W:0] r;
    r = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++)
      if (v[i]) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  pipe_state_e             state_q, state_d;
  logic [NUM_STAGES-1:1]   valid_q, valid_nxt;
  logic [NUM_STAGES-1:0]   valid_all;
  logic [NUM_STAGES-1:0]   stall_vec, flush_vec;
  logic [IDX_W:0]          s_enc, f_enc;
  logic                    s_found, f_found;
  logic [IDX_W-1:0]        s_idx, f_idx;
  logic                    active;
  logic                    stall_hon, flush_hon;

  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign valid_all = {valid_q, state_q == RUN};

  // WB cannot stall and IF cannot redirect, so those request bits are masked.
  assign stall_vec = stall_req & valid_all & {1'b0, {(NUM_STAGES-1){1'b1}}};
  assign flush_vec = flush_req & valid_all & {{(NUM_STAGES-1){1'b1}}, 1'b0};

  assign s_enc   = top_bit(stall_vec);
  assign f_enc   = top_bit(flush_vec);
  assign s_found = s_enc[IDX_W];
  assign s_idx   = s_enc[IDX_W-1:0];
  assign f_found = f_enc[IDX_W];
  assign f_idx   = f_enc[IDX_W-1:0];

  always_comb begin
    reg_en     = '0;
    reg_bubble = '0;
    redirect   = 1'b0;
    stall_hon  = 1'b0;
    flush_hon  = 1'b0;
    if (active) begin
      if (f_found && (!s_found || (f_idx > s_idx))) begin
        flush_hon = 1'b1;
        reg_en    = '1;
        for (int unsigned i = 1; i < NUM_STAGES; i++)
          if (i <= 32'(f_idx)) reg_bubble[i] = 1'b1;
      end else if (s_found) begin
        stall_hon = 1'b1;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
          if (i == 32'(s_idx) + 1) begin
            reg_en[i]     = 1'b1;
            reg_bubble[i] = 1'b1;
          end else if (i > 32'(s_idx) + 1) begin
            reg_en[i] = 1'b1;
          end
        end
      end else begin
        reg_en = '1;
      end
      // Draining: PC frozen and nothing new enters decode; a flush still kills
      // younger work but must not steer the PC.
      if (state_q == DRAIN) begin
        reg_en[0]     = 1'b0;
        reg_bubble[1] = reg_en[1];
      end
      redirect = flush_hon && (state_q == RUN);
    end
  end

  always_comb begin
    valid_nxt = valid_q;
    for (int unsigned i = 1; i < NUM_STAGES; i++)
      if (reg_en[i]) valid_nxt[i] = reg_bubble[i] ? 1'b0 : valid_all[i-1];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)             state_d = RUN;
      RUN:     if (halt_req)          state_d = DRAIN;
      DRAIN:   if (valid_nxt == '0)   state_d = HALTED;
      HALTED:                         state_d = HALTED;
      default:                        state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_nxt;
    end
  end

  assign stage_valid = valid_all;
  assign state       = state_q;

  pipe_perf_cnt #(
    .CNT_W (CNT_W)
  ) u_perf (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .cycle_en    (active),
    .instret_en  (active && valid_q[NUM_STAGES-1]),
    .stall_en    (stall_hon),
    .flush_en    (flush_hon),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with a 5-stage pipe.
module tb_pipeline_controller;

  localparam int N     = 5;
  localparam int CNT_W = 32;

  logic             sys_clk;
  logic             rst;
  logic             start;
  logic             halt_req;
  logic [N-1:0]     stall_req;
  logic [N-1:0]     flush_req;
  logic [N-1:0]     reg_en;
  logic [N-1:0]     reg_bubble;
  logic             redirect;
  logic [N-1:0]     stage_valid;
  logic [1:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int n_checks;
  int n_pass;

  logic [CNT_W-1:0] cy0, ir0, st0, fl0;

  pipeline_controller #(
    .NUM_STAGES (N),
    .CNT_W      (CNT_W)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .stall_req   (stall_req),
    .flush_req   (flush_req),
    .reg_en      (reg_en),
    .reg_bubble  (reg_bubble),
    .redirect    (redirect),
    .stage_valid (stage_valid),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    halt_req  = 1'b0;
    stall_req = '0;
    flush_req = '0;
    step(2);
    rst = 1'b0;
    check("rst_state", 64'(state), 64'd0);
    check("rst_reg_en", 64'(reg_en), 64'd0);
    check("rst_valid", 64'(stage_valid), 64'd0);
    check("rst_cycle", 64'(cycle_cnt), 64'd0);
    step(3);
    check("idle_state", 64'(state), 64'd0);
    check("idle_reg_en", 64'(reg_en), 64'd0);
    check("idle_cycle", 64'(cycle_cnt), 64'd0);

    // start-up fill
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("run_state", 64'(state), 64'd1);
    check("run_reg_en", 64'(reg_en), 64'b11111);
    check("run_valid0", 64'(stage_valid), 64'b00001);
    step(4);
    check("fill_valid", 64'(stage_valid), 64'b11111);
    check("fill_cycle", 64'(cycle_cnt), 64'd4);

    // single-cycle stall at stage 1
    st0 = stall_cnt;
    stall_req = 5'b00010;
    #1;
    check("stl1_reg_en", 64'(reg_en), 64'b11100);
    check("stl1_bubble", 64'(reg_bubble), 64'b00100);
    check("stl1_redir", 64'(redirect), 64'd0);
    step(1);
    stall_req = '0;
    check("stl1_cnt", 64'(stall_cnt), 64'(st0 + 1));
    check("stl1_valid", 64'(stage_valid), 64'b11011);
    step(3);
    check("stl1_refill", 64'(stage_valid), 64'b11111);

    // stage-2 stall held three cycles: WB sees a three-cycle gap
    st0 = stall_cnt; ir0 = instret_cnt; cy0 = cycle_cnt;
    stall_req = 5'b00100;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stl2_reg_en", 64'(reg_en), 64'b11000);
      check("stl2_bubble", 64'(reg_bubble), 64'b01000);
      step(1);
    end
    stall_req = '0;
    step(2);
    check("stl2_cnt", 64'(stall_cnt), 64'(st0 + 3));
    check("stl2_instret", 64'(instret_cnt), 64'(ir0 + 2));
    check("stl2_cycle", 64'(cycle_cnt), 64'(cy0 + 5));
    check("stl2_refill", 64'(stage_valid), 64'b11111);

    // ignored request bits: WB stall, IF flush
    st0 = stall_cnt; fl0 = flush_cnt;
    stall_req = 5'b10000;
    flush_req = 5'b00001;
    #1;
    check("ign_reg_en", 64'(reg_en), 64'b11111);
    check("ign_bubble", 64'(reg_bubble), 64'd0);
    check("ign_redir", 64'(redirect), 64'd0);
    step(1);
    stall_req = '0; flush_req = '0;
    check("ign_stall_cnt", 64'(stall_cnt), 64'(st0));
    check("ign_flush_cnt", 64'(flush_cnt), 64'(fl0));

    // flush at MEM overrides younger stall at ID
    st0 = stall_cnt; fl0 = flush_cnt;
    stall_req = 5'b00010;
    flush_req = 5'b01000;
    #1;
    check("fl3_redir", 64'(redirect), 64'd1);
    check("fl3_reg_en", 64'(reg_en), 64'b11111);
    check("fl3_bubble", 64'(reg_bubble), 64'b01110);
    step(1);
    stall_req = '0; flush_req = '0;
    check("fl3_flush_cnt", 64'(flush_cnt), 64'(fl0 + 1));
    check("fl3_stall_cnt", 64'(stall_cnt), 64'(st0));
    check("fl3_valid", 64'(stage_valid), 64'b10001);
    step(4);
    check("fl3_refill", 64'(stage_valid), 64'b11111);

    // flush at EX deferred behind older stall at MEM
    st0 = stall_cnt; fl0 = flush_cnt;
    stall_req = 5'b01000;
    flush_req = 5'b00100;
    #1;
    check("def_redir", 64'(redirect), 64'd0);
    check("def_reg_en", 64'(reg_en), 64'b10000);
    check("def_bubble", 64'(reg_bubble), 64'b10000);
    step(1);
    stall_req = '0;
    #1;
    check("def_valid", 64'(stage_valid), 64'b01111);
    check("def_redir2", 64'(redirect), 64'd1);
    check("def_reg_en2", 64'(reg_en), 64'b11111);
    check("def_bubble2", 64'(reg_bubble), 64'b00110);
    step(1);
    flush_req = '0;
    check("def_valid2", 64'(stage_valid), 64'b11001);
    check("def_flush_cnt", 64'(flush_cnt), 64'(fl0 + 1));
    check("def_stall_cnt", 64'(stall_cnt), 64'(st0 + 1));
    step(4);
    check("def_refill", 64'(stage_valid), 64'b11111);

    // halt and drain
    halt_req = 1'b1;
    #1;
    check("halt_reg_en", 64'(reg_en), 64'b11111);
    step(1);
    halt_req = 1'b0;
    check("drain_state", 64'(state), 64'd2);
    check("drain_reg_en", 64'(reg_en), 64'b11110);
    check("drain_bubble", 64'(reg_bubble), 64'b00010);
    check("drain_redir", 64'(redirect), 64'd0);
    ir0 = instret_cnt; cy0 = cycle_cnt;
    step(3);
    check("drain_state3", 64'(state), 64'd2);
    step(1);
    check("halted_state", 64'(state), 64'd3);
    check("halted_instret", 64'(instret_cnt), 64'(ir0 + 4));
    check("halted_cycle", 64'(cycle_cnt), 64'(cy0 + 4));
    check("halted_valid", 64'(stage_valid), 64'd0);
    check("halted_reg_en", 64'(reg_en), 64'd0);
    start = 1'b1;
    step(3);
    start = 1'b0;
    check("halted_hold", 64'(state), 64'd3);
    check("halted_frozen", 64'(cycle_cnt), 64'(cy0 + 4));

    // reset from HALTED
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst2_state", 64'(state), 64'd0);
    check("rst2_cycle", 64'(cycle_cnt), 64'd0);
    check("rst2_instret", 64'(instret_cnt), 64'd0);
    check("rst2_stall", 64'(stall_cnt), 64'd0);
    check("rst2_flush", 64'(flush_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
